// File: rtl/bram_table_writer_pkg.sv
// Shared types and S-box table defaults for the BRAM table writer.
package bram_table_writer_pkg;

  localparam int SBOX_ADDR_W = 10;
  localparam int SBOX_DATA_W = 8;
  localparam int SBOX_DEPTH  = 1024;
  // Array read plus output register (REGCE driven from the port enable).
  localparam int BRAM_RD_LAT = 2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WRITE  = 2'd1,
    ST_VERIFY = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

endpackage

// File: rtl/bram_table_writer_if.sv
// Byte stream in plus one BRAM port out; master is the writer side.
interface bram_table_writer_if
  import bram_table_writer_pkg::*;
#(
  parameter int ADDR_W = SBOX_ADDR_W,
  parameter int DATA_W = SBOX_DATA_W
);

  logic [DATA_W-1:0] din;
  logic              din_valid;
  logic              din_ready;
  logic              bram_en;
  logic              bram_we;
  logic [ADDR_W-1:0] bram_addr;
  logic [DATA_W-1:0] bram_di;
  logic [DATA_W-1:0] bram_do;

  modport master (
    input  din, din_valid, bram_do,
    output din_ready, bram_en, bram_we, bram_addr, bram_di
  );

  modport slave (
    output din, din_valid, bram_do,
    input  din_ready, bram_en, bram_we, bram_addr, bram_di
  );

endinterface

// File: rtl/bram_table_writer_table_checksum.sv
// XOR and modular-sum accumulator over a byte stream; clear has priority over en.
module table_checksum
  import bram_table_writer_pkg::*;
#(
  parameter int DATA_W = SBOX_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              en,
  input  logic [DATA_W-1:0] data,
  output logic [DATA_W-1:0] xor_acc,
  output logic [DATA_W-1:0] sum_acc
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      xor_acc <= '0;
      sum_acc <= '0;
    end else if (clear) begin
      xor_acc <= '0;
      sum_acc <= '0;
    end else if (en) begin
      xor_acc <= xor_acc ^ data;
      sum_acc <= sum_acc + data;
    end
  end

endmodule

// File: rtl/bram_table_writer.sv
// Streams a full table image into one BRAM port, optionally reads it back and
// compares running checksums.
//
//   state     | meaning
//   ----------+-------------------------------------------------------------
//   ST_IDLE   | after reset, waiting for start
//   ST_WRITE  | accepting bytes, one BRAM write per handshake
//   ST_VERIFY | streaming reads 0..DEPTH-1, accumulating tagged read data
//   ST_DONE   | load finished, err valid, waiting for the next start
module bram_table_writer
  import bram_table_writer_pkg::*;
#(
  parameter int ADDR_W = SBOX_ADDR_W,
  parameter int DATA_W = SBOX_DATA_W,
  parameter int DEPTH  = SBOX_DEPTH,
  parameter int RD_LAT = BRAM_RD_LAT
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                verify_en,
  bram_table_writer_if.master bus,
  output logic                busy,
  output logic                done,
  output logic                err
);

  localparam int                CNT_W     = ADDR_W + 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0]  DEPTH_CNT = CNT_W'(DEPTH);

  state_t state, state_nxt;

  logic [ADDR_W-1:0] wr_addr;
  logic [CNT_W-1:0]  rd_cnt;
  logic [CNT_W-1:0]  ret_left;
  logic [RD_LAT-1:0] vld_sr;
  logic              verify_lat;

  logic start_acc, wr_fire, wr_last, rd_issue, rd_tag, rd_last;

  logic [DATA_W-1:0] chk_xor, chk_sum, rb_xor, rb_sum;

  logic              din_ready_c, bram_en_c, bram_we_c;
  logic [ADDR_W-1:0] bram_addr_c;
  logic [DATA_W-1:0] bram_di_c;

  assign start_acc = start && ((state == ST_IDLE) || (state == ST_DONE));
  assign wr_fire   = (state == ST_WRITE) && bus.din_valid;
  assign wr_last   = (wr_addr == LAST_ADDR);
  assign rd_issue  = (state == ST_VERIFY) && (rd_cnt < DEPTH_CNT);
  assign rd_tag    = (state == ST_VERIFY) && vld_sr[RD_LAT-1];
  assign rd_last   = rd_tag && (ret_left == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE, ST_DONE: if (start) state_nxt = ST_WRITE;
      ST_WRITE:         if (wr_fire && wr_last) state_nxt = verify_lat ? ST_VERIFY : ST_DONE;
      ST_VERIFY:        if (rd_last) state_nxt = ST_DONE;
      default:          state_nxt = ST_IDLE;
    endcase
  end

  // Enable stays high for the whole VERIFY phase: it also clocks the BRAM
  // output register, so it must keep running while the last reads drain.
  always_comb begin
    din_ready_c = 1'b0;
    bram_en_c   = 1'b0;
    bram_we_c   = 1'b0;
    bram_addr_c = '0;
    bram_di_c   = '0;
    busy        = 1'b0;
    done        = 1'b0;
    err         = 1'b0;
    case (state)
      ST_WRITE: begin
        busy        = 1'b1;
        din_ready_c = 1'b1;
        if (bus.din_valid) begin
          bram_en_c   = 1'b1;
          bram_we_c   = 1'b1;
          bram_addr_c = wr_addr;
          bram_di_c   = bus.din;
        end
      end
      ST_VERIFY: begin
        busy        = 1'b1;
        bram_en_c   = 1'b1;
        bram_addr_c = rd_issue ? rd_cnt[ADDR_W-1:0] : LAST_ADDR;
      end
      ST_DONE: begin
        done = 1'b1;
        err  = verify_lat && ((rb_xor != chk_xor) || (rb_sum != chk_sum));
      end
      default: ;
    endcase
  end

  assign bus.din_ready = din_ready_c;
  assign bus.bram_en   = bram_en_c;
  assign bus.bram_we   = bram_we_c;
  assign bus.bram_addr = bram_addr_c;
  assign bus.bram_di   = bram_di_c;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_addr    <= '0;
      rd_cnt     <= '0;
      ret_left   <= '0;
      vld_sr     <= '0;
      verify_lat <= 1'b0;
    end else begin
      for (int i = RD_LAT - 1; i > 0; i--) vld_sr[i] <= vld_sr[i-1];
      vld_sr[0] <= rd_issue;
      if (start_acc) begin
        wr_addr    <= '0;
        rd_cnt     <= '0;
        ret_left   <= DEPTH_CNT - 1'b1;
        verify_lat <= verify_en;
      end else begin
        if (wr_fire && !wr_last)      wr_addr  <= wr_addr + 1'b1;
        if (rd_issue)                 rd_cnt   <= rd_cnt + 1'b1;
        if (rd_tag && ret_left != '0) ret_left <= ret_left - 1'b1;
      end
    end
  end

  table_checksum #(.DATA_W(DATA_W)) u_chk_wr (
    .clk     (clk),
    .rst     (rst),
    .clear   (start_acc),
    .en      (wr_fire),
    .data    (bus.din),
    .xor_acc (chk_xor),
    .sum_acc (chk_sum)
  );

  table_checksum #(.DATA_W(DATA_W)) u_chk_rb (
    .clk     (clk),
    .rst     (rst),
    .clear   (start_acc),
    .en      (rd_tag),
    .data    (bus.bram_do),
    .xor_acc (rb_xor),
    .sum_acc (rb_sum)
  );

endmodule

// File: tb/tb_bram_table_writer.sv
// Directed bench for bram_table_writer with a behavioural RD_LAT=2 BRAM and a write scoreboard.
module tb_bram_table_writer;

  localparam int DEPTH = 1024;
  localparam int LIMIT = 6000;

  logic clk, rst, start, verify_en;
  logic busy, done, err;

  bram_table_writer_if #(.ADDR_W(10), .DATA_W(8)) bus ();

  bram_table_writer dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .verify_en (verify_en),
    .bus       (bus.master),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural BRAM: WRITE_FIRST array stage plus output register, both on bram_en.
  logic [7:0] mem [DEPTH];
  logic [7:0] s1, do_r;
  bit         flip;
  always @(posedge clk) begin
    if (bus.bram_en) begin
      if (bus.bram_we) begin
        mem[bus.bram_addr] <= bus.bram_di;
        s1 <= bus.bram_di;
      end else begin
        s1 <= mem[bus.bram_addr] ^ ((flip && bus.bram_addr == 10'd5) ? 8'h01 : 8'h00);
      end
      do_r <= s1;
    end
  end
  assign bus.bram_do = do_r;

  int vectors = 0;
  int miscompares = 0;
  int rd_seen = 0;
  logic [17:0] exp_q[$];
  logic [7:0]  exp_xor, exp_sum;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      $error("%s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    logic [17:0] e;
    #2;
    if (!rst) begin
      if (bus.bram_we) begin
        check("we_with_en", {31'd0, bus.bram_en}, 32'd1);
        if (exp_q.size() == 0) check("spurious_write", 32'd1, 32'd0);
        else begin
          e = exp_q.pop_front();
          check("write_addr_data", {14'd0, bus.bram_addr, bus.bram_di}, {14'd0, e});
        end
      end else if (bus.bram_en) begin
        if (rd_seen < DEPTH) check("read_addr", {22'd0, bus.bram_addr}, {22'd0, rd_seen[9:0]});
        rd_seen++;
      end
    end
  end

  task automatic check_outputs_zero(input string tag);
    check({tag, "_outs"},
          {20'd0, bus.din_ready, bus.bram_en, bus.bram_we, busy, done, err, 6'd0},
          32'd0);
    check({tag, "_addr_di"}, {14'd0, bus.bram_addr, bus.bram_di}, 32'd0);
  endtask

  task automatic do_load(input bit ver, input bit gaps, input int start_at, input int rst_at,
                         output int cyc, output bit aborted);
    int a;
    a = 0;
    aborted = 1'b0;
    exp_xor = 8'h00;
    exp_sum = 8'h00;
    rd_seen = 0;
    @(negedge clk);
    start = 1'b1;
    verify_en = ver;
    @(negedge clk);
    start = 1'b0;
    verify_en = 1'b0;
    cyc = 1;
    while (!done && cyc < LIMIT) begin
      start = (a == start_at) ? 1'b1 : 1'b0;
      bus.din_valid = 1'b0;
      if (a < DEPTH) begin
        if (!gaps || (cyc % 2 == 1)) begin
          bus.din_valid = 1'b1;
          bus.din = a[7:0];
          if (a == rst_at) begin
            rst = 1'b1;
            #1;
            check_outputs_zero("reset_mid_write");
            @(negedge clk);
            rst = 1'b0;
            bus.din_valid = 1'b0;
            exp_q.delete();
            aborted = 1'b1;
            return;
          end
          exp_q.push_back({a[9:0], a[7:0]});
          exp_xor = exp_xor ^ a[7:0];
          exp_sum = exp_sum + a[7:0];
          a++;
        end
      end else if (ver) begin
        bus.din_valid = 1'b1;
        bus.din = 8'hA5;
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    bus.din_valid = 1'b0;
  endtask

  task automatic post_checks(input string name, input int cyc, input int exp_cyc,
                             input bit exp_err, input int exp_rd, input bit ver);
    check({name, "_cycles"}, cyc, exp_cyc);
    check({name, "_done"}, {31'd0, done}, 32'd1);
    check({name, "_err"}, {31'd0, err}, {31'd0, exp_err});
    check({name, "_idle_flags"}, {30'd0, busy, bus.din_ready}, 32'd0);
    check({name, "_queue_empty"}, exp_q.size(), 32'd0);
    check({name, "_read_cycles"}, rd_seen, exp_rd);
    check({name, "_chk_wr"}, {16'd0, dut.chk_xor, dut.chk_sum}, {16'd0, exp_xor, exp_sum});
    if (ver && !exp_err)
      check({name, "_chk_rb"}, {16'd0, dut.rb_xor, dut.rb_sum}, {16'd0, exp_xor, exp_sum});
  endtask

  initial begin
    int  cyc;
    bit  ab;
    rst = 1'b1;
    start = 1'b0;
    verify_en = 1'b0;
    flip = 1'b0;
    bus.din = 8'h00;
    bus.din_valid = 1'b0;
    #3;
    check_outputs_zero("reset");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    bus.din_valid = 1'b1;
    bus.din = 8'h3C;
    #2;
    check("idle_ignores_valid", {30'd0, bus.din_ready, bus.bram_we}, 32'd0);
    bus.din_valid = 1'b0;

    do_load(1'b0, 1'b0, -1, -1, cyc, ab);
    post_checks("plain", cyc, 1025, 1'b0, 0, 1'b0);

    do_load(1'b1, 1'b0, -1, -1, cyc, ab);
    post_checks("verify", cyc, 2051, 1'b0, 1026, 1'b1);

    flip = 1'b1;
    do_load(1'b1, 1'b0, -1, -1, cyc, ab);
    post_checks("verify_flip", cyc, 2051, 1'b1, 1026, 1'b1);
    flip = 1'b0;

    do_load(1'b0, 1'b1, -1, -1, cyc, ab);
    post_checks("valid_gaps", cyc, 2048, 1'b0, 0, 1'b0);

    do_load(1'b0, 1'b0, 100, -1, cyc, ab);
    post_checks("start_while_busy", cyc, 1025, 1'b0, 0, 1'b0);

    do_load(1'b1, 1'b0, -1, 300, cyc, ab);
    check("reset_aborted", {31'd0, ab}, 32'd1);
    #2;
    check_outputs_zero("after_reset");

    do_load(1'b1, 1'b0, -1, -1, cyc, ab);
    post_checks("reload", cyc, 2051, 1'b0, 1026, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
